// File: rtl/cxu_l2_rr_arb.sv
// Round-robin arbiter sharing one CXU-L2 subordinate port among N_REQS requesters.
// A small in-order tag FIFO remembers who won each downstream handshake so responses can be steered back.
module cxu_l2_rr_arb #(
    parameter int N_REQS       = 2,
    parameter int CXU_ID_W     = 1,
    parameter int STATE_ID_W   = 1,
    parameter int INSN_W       = 32,
    parameter int FUNC_ID_W    = 10,
    parameter int DATA_W       = 32,
    parameter int STATUS_W     = 3,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_en,
    input  logic [N_REQS-1:0]            req_valid,
    output logic [N_REQS-1:0]            req_ready,
    input  logic [N_REQS*CXU_ID_W-1:0]   req_cxu,
    input  logic [N_REQS*STATE_ID_W-1:0] req_state,
    input  logic [N_REQS*INSN_W-1:0]     req_insn,
    input  logic [N_REQS*FUNC_ID_W-1:0]  req_func,
    input  logic [N_REQS*DATA_W-1:0]     req_data0,
    input  logic [N_REQS*DATA_W-1:0]     req_data1,
    output logic [N_REQS-1:0]            resp_valid,
    input  logic [N_REQS-1:0]            resp_ready,
    output logic [N_REQS*STATUS_W-1:0]   resp_status,
    output logic [N_REQS*DATA_W-1:0]     resp_data,
    output logic                         t_req_valid,
    input  logic                         t_req_ready,
    output logic [CXU_ID_W-1:0]          t_req_cxu,
    output logic [STATE_ID_W-1:0]        t_req_state,
    output logic [INSN_W-1:0]            t_req_insn,
    output logic [FUNC_ID_W-1:0]         t_req_func,
    output logic [DATA_W-1:0]            t_req_data0,
    output logic [DATA_W-1:0]            t_req_data1,
    input  logic                         t_resp_valid,
    output logic                         t_resp_ready,
    input  logic [STATUS_W-1:0]          t_resp_status,
    input  logic [DATA_W-1:0]            t_resp_data
);

    localparam int IDX_W = (N_REQS > 1) ? $clog2(N_REQS) : 1;
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] fifo_q [MAX_INFLIGHT];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] head;
    logic             any_req;
    logic             issue_ok;
    logic             fifo_nonempty;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Scan from the farthest candidate back to the nearest so the nearest valid one wins.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] idx_l;
        idx   = 0;
        idx_l = '0;
        grant = IDX_W'((int'(last_grant_q) + 1) % N_REQS);
        if (lock_q) begin
            grant   = lock_idx_q;
            any_req = req_valid[lock_idx_q];
        end else begin
            any_req = |req_valid;
            for (int k = N_REQS; k >= 1; k--) begin
                idx   = (int'(last_grant_q) + k) % N_REQS;
                idx_l = IDX_W'(idx);
                if (req_valid[idx_l]) grant = idx_l;
            end
        end
    end

    assign fifo_nonempty = (count_q != '0);
    assign issue_ok      = clk_en && (count_q < CNT_W'(MAX_INFLIGHT));
    assign head          = fifo_q[rd_ptr_q];
    assign t_req_valid   = issue_ok && any_req;
    assign t_resp_ready  = clk_en && fifo_nonempty && resp_ready[head];
    assign push          = t_req_valid && t_req_ready;
    assign pop           = t_resp_valid && t_resp_ready;

    always_comb begin
        t_req_cxu   = '0;
        t_req_state = '0;
        t_req_insn  = '0;
        t_req_func  = '0;
        t_req_data0 = '0;
        t_req_data1 = '0;
        for (int i = 0; i < N_REQS; i++) begin
            if (grant == IDX_W'(i)) begin
                t_req_cxu   = req_cxu[i*CXU_ID_W +: CXU_ID_W];
                t_req_state = req_state[i*STATE_ID_W +: STATE_ID_W];
                t_req_insn  = req_insn[i*INSN_W +: INSN_W];
                t_req_func  = req_func[i*FUNC_ID_W +: FUNC_ID_W];
                t_req_data0 = req_data0[i*DATA_W +: DATA_W];
                t_req_data1 = req_data1[i*DATA_W +: DATA_W];
            end
        end
    end

    // Response payload is broadcast; only the slice at the FIFO head sees valid.
    generate
        for (genvar gi = 0; gi < N_REQS; gi++) begin : g_port
            assign req_ready[gi]  = issue_ok && (grant == IDX_W'(gi)) && t_req_ready;
            assign resp_valid[gi] = clk_en && fifo_nonempty && t_resp_valid && (head == IDX_W'(gi));
            assign resp_status[gi*STATUS_W +: STATUS_W] = t_resp_status;
            assign resp_data[gi*DATA_W +: DATA_W]       = t_resp_data;
        end
    endgenerate

    always_comb begin
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        lock_idx_d   = lock_idx_q;
        count_d      = count_q;
        wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        if (push) begin
            last_grant_d = grant;
            lock_d       = 1'b0;
        end else if (t_req_valid && !t_req_ready) begin
            // Pin the presented request so later arrivals cannot change the payload.
            lock_d     = 1'b1;
            lock_idx_d = grant;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= IDX_W'(N_REQS - 1);
            lock_q       <= 1'b0;
            lock_idx_q   <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            lock_idx_q   <= lock_idx_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            if (push) fifo_q[wr_ptr_q] <= grant;
        end
    end

    a_lock_held: assert property (@(posedge clk) disable iff (rst)
        !(lock_q && !req_valid[lock_idx_q]));
    a_resp_expected: assert property (@(posedge clk) disable iff (rst)
        !(t_resp_valid && (count_q == '0)));

endmodule

// File: tb/tb_cxu_l2_rr_arb.sv
// Bench for cxu_l2_rr_arb: 1-cycle adder model downstream, response scoreboard, grant vector table.
module tb_cxu_l2_rr_arb;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam logic [31:0] INSN0 = 32'hA000_0000;
    localparam logic [31:0] INSN1 = 32'hB111_1111;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_en;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  req_cxu;
    logic [N-1:0]  req_state;
    logic [N*32-1:0] req_insn;
    logic [N*10-1:0] req_func;
    logic [N*DW-1:0] req_data0, req_data1;
    logic [N-1:0]  resp_valid;
    logic [N-1:0]  resp_ready;
    logic [N*3-1:0]  resp_status;
    logic [N*DW-1:0] resp_data;
    logic          t_req_valid, t_req_ready;
    logic [0:0]    t_req_cxu, t_req_state;
    logic [31:0]   t_req_insn;
    logic [9:0]    t_req_func;
    logic [DW-1:0] t_req_data0, t_req_data1;
    logic          t_resp_valid, t_resp_ready;
    logic [2:0]    t_resp_status;
    logic [DW-1:0] t_resp_data;

    logic [DW-1:0] d0 [N];
    logic [DW-1:0] d1 [N];

    assign req_data0 = {d0[1], d0[0]};
    assign req_data1 = {d1[1], d1[0]};
    assign req_insn  = {INSN1, INSN0};
    assign req_func  = {10'h2B1, 10'h1A0};
    assign req_cxu   = 2'b10;
    assign req_state = 2'b01;

    cxu_l2_rr_arb #(
        .N_REQS(N), .CXU_ID_W(1), .STATE_ID_W(1), .INSN_W(32), .FUNC_ID_W(10),
        .DATA_W(DW), .STATUS_W(3), .MAX_INFLIGHT(4)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cxu(req_cxu), .req_state(req_state), .req_insn(req_insn),
        .req_func(req_func), .req_data0(req_data0), .req_data1(req_data1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_status(resp_status), .resp_data(resp_data),
        .t_req_valid(t_req_valid), .t_req_ready(t_req_ready),
        .t_req_cxu(t_req_cxu), .t_req_state(t_req_state), .t_req_insn(t_req_insn),
        .t_req_func(t_req_func), .t_req_data0(t_req_data0), .t_req_data1(t_req_data1),
        .t_resp_valid(t_resp_valid), .t_resp_ready(t_resp_ready),
        .t_resp_status(t_resp_status), .t_resp_data(t_resp_data)
    );

    always #5 clk = ~clk;

    // Shared CXU model: adds the operands, answers one cycle after acceptance, in order.
    logic [DW-1:0] ds_mem [16];
    int            ds_wr = 0;
    int            ds_rd = 0;
    logic          ds_en;

    always @(posedge clk) begin
        if (rst) begin
            ds_wr <= 0;
            ds_rd <= 0;
        end else begin
            if (t_req_valid && t_req_ready) begin
                ds_mem[ds_wr[3:0]] <= t_req_data0 + t_req_data1;
                ds_wr <= ds_wr + 1;
            end
            if (t_resp_valid && t_resp_ready) ds_rd <= ds_rd + 1;
        end
    end

    assign t_resp_valid  = ds_en && (ds_wr != ds_rd);
    assign t_resp_data   = ds_mem[ds_rd[3:0]];
    assign t_resp_status = 3'b101;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [0:0]  idx;
        logic [31:0] data;
    } sb_t;
    sb_t sb [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Accepted requests feed the scoreboard; delivered responses are checked against it.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{idx: 1'(i), data: d0[i] + d1[i]});
                    $display("REQ  port=%0d data0=%0d data1=%0d", i, d0[i], d1[i]);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (resp_valid[i] && resp_ready[i]) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 64'(i), 64'hFFFF);
                    end else begin
                        sb_t e;
                        e = sb.pop_front();
                        $display("RESP port=%0d data=%0d exp_port=%0d exp_data=%0d",
                                 i, resp_data[i*DW +: DW], e.idx, e.data);
                        chk("resp_port", 64'(i), 64'(e.idx));
                        chk("resp_data", 64'(resp_data[i*DW +: DW]), 64'(e.data));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid  = '0;
        ds_en      = 1'b1;
        resp_ready = '1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) step();
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    typedef struct packed {
        logic [1:0]  rv;
        logic        trdy;
        logic [1:0]  exp_rdy;
        logic        exp_tv;
        logic [31:0] exp_insn;
    } vec_t;
    vec_t tbl [13];

    logic [DW-1:0] held;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{2'b11, 1'b1, 2'b01, 1'b1, INSN0};
        tbl[1]  = '{2'b11, 1'b1, 2'b10, 1'b1, INSN1};
        tbl[2]  = '{2'b11, 1'b1, 2'b01, 1'b1, INSN0};
        tbl[3]  = '{2'b11, 1'b1, 2'b10, 1'b1, INSN1};
        tbl[4]  = '{2'b11, 1'b1, 2'b01, 1'b1, INSN0};
        tbl[5]  = '{2'b11, 1'b1, 2'b10, 1'b1, INSN1};
        tbl[6]  = '{2'b10, 1'b1, 2'b10, 1'b1, INSN1};
        tbl[7]  = '{2'b10, 1'b1, 2'b10, 1'b1, INSN1};
        tbl[8]  = '{2'b01, 1'b0, 2'b00, 1'b1, INSN0};
        tbl[9]  = '{2'b11, 1'b0, 2'b00, 1'b1, INSN0};
        tbl[10] = '{2'b11, 1'b1, 2'b01, 1'b1, INSN0};
        tbl[11] = '{2'b11, 1'b1, 2'b10, 1'b1, INSN1};
        tbl[12] = '{2'b00, 1'b0, 2'b00, 1'b0, INSN0};

        rst = 1'b1; clk_en = 1'b1; req_valid = '0; t_req_ready = 1'b0;
        resp_ready = '1; ds_en = 1'b1;
        for (int i = 0; i < N; i++) begin d0[i] = '0; d1[i] = 32'd1; end
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_t_req_valid", 64'(t_req_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_t_resp_ready", 64'(t_resp_ready), 64'd0);
        step();

        // Single requester, back-to-back, one-cycle response latency.
        t_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 2'b01; d0[0] = 32'(i);
            @(negedge clk);
            chk("t1_req_ready", 64'(req_ready), 64'b01);
            chk("t1_t_data0", 64'(t_req_data0), 64'(i));
            chk("t1_resp_valid", 64'(resp_valid), (i > 0) ? 64'b01 : 64'b00);
            if (i > 0) chk("t1_resp_data", 64'(resp_data[DW-1:0]), 64'(i));
            step();
        end
        drain();

        // Stalled downstream: req0 stays presented while req1 arrives with priority.
        d0[0] = 32'd100; d0[1] = 32'd200;
        for (int c = 0; c < 5; c++) begin
            req_valid   = (c == 0) ? 2'b01 : 2'b11;
            t_req_ready = (c >= 3);
            @(negedge clk);
            chk("t3_t_req_valid", 64'(t_req_valid), 64'd1);
            chk("t3_insn", 64'(t_req_insn), (c < 4) ? 64'(INSN0) : 64'(INSN1));
            chk("t3_req_ready", 64'(req_ready), (c < 3) ? 64'b00 : ((c == 3) ? 64'b01 : 64'b10));
            step();
        end
        drain();

        for (int r = 0; r < 13; r++) begin
            req_valid   = tbl[r].rv;
            t_req_ready = tbl[r].trdy;
            d0[0] = 32'(r * 16);
            d0[1] = 32'(r * 16 + 8);
            @(negedge clk);
            chk("tbl_req_ready", 64'(req_ready), 64'(tbl[r].exp_rdy));
            chk("tbl_t_req_valid", 64'(t_req_valid), 64'(tbl[r].exp_tv));
            if (tbl[r].exp_tv) chk("tbl_insn", 64'(t_req_insn), 64'(tbl[r].exp_insn));
            step();
        end
        drain();

        // Head requester back-pressure stalls the shared response.
        t_req_ready = 1'b1;
        req_valid = 2'b10; d0[1] = 32'd300;
        @(negedge clk);
        chk("t5_req_ready_a", 64'(req_ready), 64'b10);
        step();
        req_valid = 2'b01; d0[0] = 32'd400; resp_ready = 2'b01;
        @(negedge clk);
        chk("t5_req_ready_b", 64'(req_ready), 64'b01);
        chk("t5_resp_valid_b", 64'(resp_valid), 64'b10);
        chk("t5_t_resp_ready_b", 64'(t_resp_ready), 64'd0);
        chk("t5_resp_status", 64'(resp_status), 64'({2{3'b101}}));
        held = resp_data[2*DW-1:DW];
        chk("t5_resp_data_b", 64'(held), 64'd301);
        step();
        req_valid = 2'b00;
        @(negedge clk);
        chk("t5_resp_valid_c", 64'(resp_valid), 64'b10);
        chk("t5_t_resp_ready_c", 64'(t_resp_ready), 64'd0);
        chk("t5_resp_data_c", 64'(resp_data[2*DW-1:DW]), 64'(held));
        step();
        resp_ready = 2'b11;
        @(negedge clk);
        chk("t5_t_resp_ready_d", 64'(t_resp_ready), 64'd1);
        step();
        @(negedge clk);
        chk("t5_resp_valid_e", 64'(resp_valid), 64'b01);
        chk("t5_resp_data_e", 64'(resp_data[DW-1:0]), 64'd401);
        step();
        drain();

        // Fill the tag FIFO with responses withheld.
        ds_en = 1'b0; t_req_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_valid = 2'b01; d0[0] = 32'(500 + k);
            if (k == 6) ds_en = 1'b1;
            @(negedge clk);
            if (k < 6) begin
                chk("t4_req_ready", 64'(req_ready), (k < 4) ? 64'b01 : 64'b00);
            end else if (k == 6) begin
                chk("t4_pop_ready", 64'(t_resp_ready), 64'd1);
                chk("t4_full_block", 64'(req_ready), 64'b00);
            end else begin
                chk("t4_after_pop", 64'(req_ready), 64'b01);
            end
            step();
        end
        drain();

        // Clock enable low freezes everything mid-stream.
        t_req_ready = 1'b1;
        req_valid = 2'b11; d0[0] = 32'd700; d0[1] = 32'd600;
        @(negedge clk);
        chk("ce_before", 64'(req_ready), 64'b10);
        step();
        clk_en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("ce_req_ready", 64'(req_ready), 64'b00);
            chk("ce_t_req_valid", 64'(t_req_valid), 64'd0);
            chk("ce_resp_valid", 64'(resp_valid), 64'b00);
            chk("ce_t_resp_ready", 64'(t_resp_ready), 64'd0);
            step();
        end
        clk_en = 1'b1;
        @(negedge clk);
        chk("ce_resume_ready", 64'(req_ready), 64'b01);
        chk("ce_resume_resp", 64'(resp_valid), 64'b10);
        step();
        @(negedge clk);
        chk("ce_next_ready", 64'(req_ready), 64'b10);
        step();
        drain();

        // Reset with two outstanding requests and a lock on requester 1.
        ds_en = 1'b0; t_req_ready = 1'b1; req_valid = 2'b01; d0[0] = 32'd800;
        step(); step();
        req_valid = 2'b11; t_req_ready = 1'b0;
        @(negedge clk);
        chk("rs_locked_insn", 64'(t_req_insn), 64'(INSN1));
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; req_valid = 2'b00; ds_en = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("rs_t_req_valid", 64'(t_req_valid), 64'd0);
        chk("rs_req_ready", 64'(req_ready), 64'b00);
        chk("rs_resp_valid", 64'(resp_valid), 64'b00);
        chk("rs_t_resp_ready", 64'(t_resp_ready), 64'd0);
        step();
        req_valid = 2'b11; t_req_ready = 1'b1;
        @(negedge clk);
        chk("rs_priority", 64'(req_ready), 64'b01);
        step();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cxu_l2_rr_arb.md
Name: cxu_l2_rr_arb

Overview:
- Shares one subordinate CXU-L2 port among N_REQS CXU-L2 requesters, such as several harts or a hart plus a DMA engine.
- Round-robin arbitration per request, combinational request mux, no added request latency.
- Downstream CXU is in-order: one response per request, responses in request order.
- An in-order tag FIFO records the winning requester of each downstream handshake. Each downstream response is steered back to that requester.
- Sits between requester CXU-L2 ports and a shared L2 CXU, for example a cvt-style L0-to-L2 adapter.

Parameters:
- N_REQS, 2, number of requesters (2..8).
- CXU_ID_W, 1, width of req_cxu.
- STATE_ID_W, 1, width of req_state.
- INSN_W, 32, width of req_insn.
- FUNC_ID_W, 10, width of req_func.
- DATA_W, 32, operand/result width.
- STATUS_W, 3, width of resp_status (CXU status code).
- MAX_INFLIGHT, 4, tag FIFO depth = max outstanding downstream requests (power of 2, ≥1).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- clk_en  input  1  clock enable; state advances only when high
- req_valid  input  N_REQS  per-requester request valid
- req_ready  output  N_REQS  per-requester request ready
- req_cxu  input  N_REQS*CXU_ID_W  packed, requester i at slice i
- req_state  input  N_REQS*STATE_ID_W  packed
- req_insn  input  N_REQS*INSN_W  packed
- req_func  input  N_REQS*FUNC_ID_W  packed
- req_data0  input  N_REQS*DATA_W  packed
- req_data1  input  N_REQS*DATA_W  packed
- resp_valid  output  N_REQS  per-requester response valid
- resp_ready  input  N_REQS  per-requester response ready
- resp_status  output  N_REQS*STATUS_W  packed
- resp_data  output  N_REQS*DATA_W  packed
- t_req_valid, t_req_cxu, t_req_state, t_req_insn, t_req_func, t_req_data0, t_req_data1  output  (single-port widths)  request to shared CXU
- t_req_ready  input  1  shared CXU request ready
- t_resp_valid  input  1  shared CXU response valid
- t_resp_ready  output  1  shared CXU response ready
- t_resp_status  input  STATUS_W  shared CXU response status
- t_resp_data  input  DATA_W  shared CXU response data

Behaviour:
- Clock and reset: one clock domain; reset is synchronous, active-high, on clk/rst. rst overrides clk_en.
- Reset values:
  - last_grant = N_REQS-1, so requester 0 has first priority.
  - lock = 0.
  - FIFO empty: rd_ptr = 0, wr_ptr = 0, count = 0.
  - All outputs are combinational from state, so after reset: t_req_valid=0, t_resp_ready=0, req_ready=0, resp_valid=0.
- Grant selection (combinational):
  - If lock=1, grant = lock_idx.
  - Otherwise grant = first i with req_valid[i], scanning last_grant+1, +2, … modulo N_REQS.
  - any = OR of the requests considered.
- Issue enable: issue_ok = clk_en && count < MAX_INFLIGHT.
  - A full FIFO blocks issue even if a pop happens in the same cycle.
- Request path:
  - t_req_valid = issue_ok && any.
  - t_req_* payload = slices of the granted requester.
  - req_ready[i] = issue_ok && (i == grant) && t_req_ready. All other req_ready bits are 0.
- Downstream handshake (t_req_valid && t_req_ready):
  - Push grant into FIFO at wr_ptr.
  - last_grant <= grant; lock <= 0.
- Lock:
  - Set when t_req_valid && !t_req_ready && clk_en, with lock_idx <= grant.
  - Guarantees a presented downstream request stays stable until accepted. Higher-priority arrivals cannot preempt it.
  - A requester must not drop req_valid while locked (protocol). A sim assertion flags it.
- Response path:
  - head = fifo[rd_ptr].
  - resp_valid[head] = clk_en && count > 0 && t_resp_valid. Other resp_valid bits are 0.
  - resp_status and resp_data are broadcast to every slice; only the head slice is qualified by valid.
  - t_resp_ready = clk_en && count > 0 && resp_ready[head].
  - Pop on t_resp_valid && t_resp_ready.
  - Back-pressure from the head requester stalls the shared CXU. This is accepted; no response buffering.
- Push and pop in the same cycle: count is unchanged and both pointers advance. Pointers wrap modulo MAX_INFLIGHT.
- t_resp_valid while count == 0:
  - Protocol error: ignored, t_resp_ready = 0.
  - Sim assertion fires.
- clk_en low:
  - All valids and readies out are 0.
  - No state change; lock is retained.
- Reset mid-operation:
  - FIFO and lock are cleared immediately.
  - Outstanding downstream responses are orphaned. The system must reset the shared CXU in the same cycle.
- Throughput:
  - One request per cycle when the downstream is ready.
  - A requester that is the only one valid may issue every cycle.

Test Plan:
1. Single requester, N_REQS=2, shared CXU with 1-cycle latency. req0 issues 4 back-to-back adds (data0=i, data1=1) -> t_req handshake every cycle; resp_valid[0] returns data i+1 one cycle after each request; resp_valid[1] never asserts.
2. Both requesters held valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; each requester gets 3 responses in order, and each response goes to the requester that issued it.
3. t_req_ready low for 3 cycles while req0 is presented, with req1 raised in cycle 1 -> t_req payload stays req0's; req0 is accepted first when ready rises; req1 is accepted next cycle.
4. MAX_INFLIGHT=4, downstream holds t_resp_valid=0 -> exactly 4 requests accepted; 5th sees req_ready=0 until one pop; a pop does not enable a push in the same cycle when full.
5. req1's response at FIFO head with resp_ready[1]=0 for 2 cycles -> t_resp_ready=0 and resp_valid[1]=1 held with stable data; req0's later response is not delivered early.
6. Assert rst with 2 outstanding requests and lock=1 -> the next cycle shows count=0, all outputs 0, and first priority back at requester 0. Separately, clk_en=0 for 2 cycles mid-stream -> no handshakes and state unchanged.
